// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  // Instruction leaving decode, as seen by the scoreboard.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wreg;
    logic                  load;
    logic                  long_op;
  } issue_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: up on long issue, down on writeback,
// saturating, with a sticky underflow flag for writebacks nobody asked for.
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             uflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uflow_q, uflow_d;
  logic             dec_ok;

  // Next count; a matched increment and effective decrement cancel out.
  always_comb begin
    cnt_d   = cnt_q;
    uflow_d = uflow_q;
    dec_ok  = dec_i && (cnt_q != '0);
    if (dec_i && (cnt_q == '0)) begin
      uflow_d = 1'b1;
    end
    if (inc_i && !dec_ok) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec_ok && !inc_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter and sticky underflow state.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q   <= '0;
      uflow_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      uflow_q <= uflow_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign busy_o  = (cnt_q != '0);
  assign uflow_o = uflow_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side scoreboard for writes that EXE/MEM forwarding cannot cover:
// a load still in EXE, and long-latency results retiring through wb_*.
module hazard_scoreboard #(
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned NUM_REGS = hazard_scoreboard_pkg::NUM_REGS
) (
  input  logic                                       clk,
  input  logic                                       nRst,
  input  logic [hazard_scoreboard_pkg::REG_ADDR_W-1:0] addr1DEC,
  input  logic [hazard_scoreboard_pkg::REG_ADDR_W-1:0] addr2DEC,
  input  logic                                       use1DEC,
  input  logic                                       use2DEC,
  input  logic                                       issue_valid,
  input  logic [hazard_scoreboard_pkg::REG_ADDR_W-1:0] issue_rd,
  input  logic                                       issue_wreg,
  input  logic                                       issue_load,
  input  logic                                       issue_long,
  input  logic                                       wb_valid,
  input  logic [hazard_scoreboard_pkg::REG_ADDR_W-1:0] wb_rd,
  input  logic                                       flush,
  output logic                                       stall,
  output logic [NUM_REGS-1:0]                        busy,
  output logic                                       err
);

  import hazard_scoreboard_pkg::*;

  issue_t                iss;
  logic [CNT_W-1:0]      cnt [NUM_REGS];
  logic [NUM_REGS-1:0]   nz;
  logic [NUM_REGS-1:0]   uflow;
  logic                  hz1, hz2, hz_full, stall_int, accept;
  logic                  inc_en, dec_en;

  logic                  ld_valid_q, ld_valid_d;
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;

  // Bundle the decode-side issue request.
  always_comb begin
    iss.valid   = issue_valid;
    iss.rd      = issue_rd;
    iss.wreg    = issue_wreg;
    iss.load    = issue_load;
    iss.long_op = issue_long;
  end

  // Hazard detection and issue acceptance; purely combinational, no added latency.
  always_comb begin
    hz1 = use1DEC && (addr1DEC != '0) &&
          ((ld_valid_q && (ld_rd_q == addr1DEC)) || (cnt[addr1DEC] != '0));
    hz2 = use2DEC && (addr2DEC != '0) &&
          ((ld_valid_q && (ld_rd_q == addr2DEC)) || (cnt[addr2DEC] != '0));
    // A further long write to a saturated register would overflow its counter.
    hz_full   = iss.valid && iss.wreg && iss.long_op && (cnt[iss.rd] == {CNT_W{1'b1}});
    stall_int = !flush && (hz1 || hz2 || hz_full);
    accept    = iss.valid && !stall_int && !flush;
    inc_en    = accept && iss.wreg && iss.long_op && (iss.rd != '0);
    dec_en    = wb_valid && (wb_rd != '0);
  end

  // Load tracker follows whatever enters EXE; a bubble or flush clears it.
  always_comb begin
    ld_valid_d = accept && iss.wreg && iss.load && (iss.rd != '0);
    ld_rd_d    = iss.rd;
  end

  // Load tracker state.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ld_valid_q <= 1'b0;
      ld_rd_q    <= '0;
    end else begin
      ld_valid_q <= ld_valid_d;
      ld_rd_q    <= ld_rd_d;
    end
  end

  // x0 is hard-wired zero and never tracked.
  assign cnt[0]   = '0;
  assign nz[0]    = 1'b0;
  assign uflow[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk    (clk),
      .nRst   (nRst),
      .inc_i  (inc_en && (iss.rd == REG_ADDR_W'(i))),
      .dec_i  (dec_en && (wb_rd == REG_ADDR_W'(i))),
      .cnt_o  (cnt[i]),
      .busy_o (nz[i]),
      .uflow_o(uflow[i])
    );
  end

  assign stall = stall_int;
  assign busy  = nz;
  assign err   = |uflow;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the decode-stage operand forwarding logic.
- Tracks every in-flight register write that EXE/MEM forwarding cannot cover:
  - load results still in EXE (load-use hazard);
  - long-latency results (multiply/divide unit) that retire later through a dedicated writeback port.
- Raises a decode stall until each such operand can be obtained from forwarding or from the register file.
- Sits beside the decode stage. Its outputs feed the pipeline-register enables and the bubble insertion into EXE.

Parameters:
- CNT_W, 2: width of the per-register pending counter. Maximum in-flight long writes per register = 2^CNT_W-1.
- NUM_REGS, 32: number of architectural registers. x0 is never tracked.

Ports:
- clk  input  1  system clock, rising edge
- nRst  input  1  asynchronous active-low reset
- addr1DEC  input  5  source register 1 of the instruction in decode
- addr2DEC  input  5  source register 2 of the instruction in decode
- use1DEC  input  1  instruction reads addr1DEC
- use2DEC  input  1  instruction reads addr2DEC
- issue_valid  input  1  decode instruction requests to advance to EXE
- issue_rd  input  5  its destination register
- issue_wreg  input  1  it writes a register
- issue_load  input  1  it is a load (data available only after MEM)
- issue_long  input  1  it is a long-latency op retiring via the wb_* port
- wb_valid  input  1  long-latency unit writes back this cycle
- wb_rd  input  5  register written by the long-latency unit
- flush  input  1  branch/jump redirect; squashes the instruction in decode and the one in EXE
- stall  output  1  hold PC/IF/DEC registers and insert a bubble into EXE
- busy  output  NUM_REGS  bit i = register i has a pending long write
- err  output  1  sticky: writeback to a register with zero pending count

Behaviour:
- Reset (async assert, sync release): all counters 0, load tracker invalid, err=0. Consequently stall=0 and busy=0.
- Load tracker: one-entry register {ld_valid, ld_rd}.
  - Each cycle it loads (accept & issue_wreg & issue_load & issue_rd!=0, issue_rd).
  - It therefore describes the load currently in EXE.
- accept = issue_valid & !stall & !flush. No state changes from an issue that is not accepted.
- Hazard per source s in {1,2}: hz_s = use_s & addr_s!=0 & ((ld_valid & ld_rd==addr_s) | cnt[addr_s]!=0).
- Full hazard: issue_valid & issue_wreg & issue_long & cnt[issue_rd]==max.
- stall = !flush & (hz_1 | hz_2 | full hazard).
  - stall is combinational from current state and decode inputs; it adds zero latency.
- A load-use stall lasts exactly 1 cycle. The next cycle ld_valid=0 (a bubble was inserted), so MEM forwarding supplies the data.
- Counters:
  - Increment on accept & issue_wreg & issue_long & issue_rd!=0.
  - Decrement on wb_valid & wb_rd!=0 & cnt[wb_rd]!=0.
  - Increment and decrement of the same register in one cycle: counter unchanged.
  - Decrement when the counter is 0: counter stays 0 and err is set until reset.
  - Counters never wrap; the full hazard prevents overflow.
- A writeback in the same cycle as a dependent decode does not clear stall that cycle. Operands become visible the next cycle via the register file.
- flush:
  - clears ld_valid on the next edge (the EXE load is squashed);
  - forces stall=0;
  - blocks accept.
  - Long ops already issued are committed and their counters are untouched.
- busy[i] = cnt[i]!=0; busy[0] is always 0.
- Issue and writeback are ignored for rd==0.

Decomposition:
- Shared pipeline package:
  - REG_ADDR_W=5 and NUM_REGS;
  - a typedef for the issue bundle {valid, rd, wreg, load, long}.
- One natural sub-module: sb_counter, the per-register saturating up/down counter with underflow flag. Instantiate it NUM_REGS-1 times with a generate loop; OR-reduce the underflow flags into err.

Test Plan:
- Load-use hazard:
  - Issue a load with rd=5.
  - Next cycle decode has addr1DEC=5, use1DEC=1 -> stall=1 for exactly 1 cycle, then 0.
  - Same case with use1DEC=0 -> stall=0.
- Long op:
  - Issue long rd=7, then a dependent with addr2DEC=7 -> stall=1 and busy[7]=1.
  - Apply wb_valid, wb_rd=7 -> cycle after: cnt=0, busy[7]=0, stall=0.
- Saturation:
  - Issue 3 long ops to rd=9 (CNT_W=2) -> cnt=3.
  - Fourth long issue to rd=9 -> stall=1 until one writeback, then accepted.
  - Counter never exceeds 3.
- Simultaneous events:
  - With cnt[4]=1, an accepted long issue to rd=4 and wb_rd=4 in the same cycle -> cnt[4] remains 1.
  - Writeback to a register with cnt=0 -> err=1 and stays 1.
- x0 and flush:
  - Load with rd=0 followed by a dependent on x0 -> no stall.
  - Load rd=3 followed by flush -> ld_valid cleared and stall=0.
  - A pending long op to rd=3 stays busy through the flush.
- Reset mid-operation:
  - Assert nRst low while cnt[7]=2 and ld_valid=1 -> stall, busy and err are 0 immediately, without a clock edge.
  - After release, the first accepted issue behaves as from clean state.
